multicaster: RTL and testbench

Per-column tag-filtering stage between the horizontal data bus and one processing element. It accepts ifmap/filter/psum beats from the bus, keeps only the beats whose tag addresses this column (or the broadcast tag), and buffers them in a small FIFO that feeds the PE over a valid/ready handshake. It also returns PE partial sums to the bus through a one-entry register slice, and drains on a bus flush request.

---
 rtl/multicaster.sv | 198 +++++++++++++++++++
 tb/tb_multicaster.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicaster.sv
// Column tag filter: matched bus beats -> FIFO -> PE (1-cycle latency); PE psum -> 1-entry slice -> bus.
// Backpressure via b_ready (full/flush/disabled) and p2m_ready; optional drop counter under MULTICASTER_DROP_CNT_EN.
module multicaster #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_W     = $clog2(NUM_COL) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TAG_W-1:0]        ID,
  input  logic                    CASTER_EN,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [TAG_W-1:0]        b_tag,
  input  logic [DATA_WIDTH-1:0]   ifmap_data_B2M,
  input  logic [DATA_WIDTH-1:0]   fltr_data_B2M,
  input  logic [2*DATA_WIDTH-1:0] psum_data_B2M,
  input  logic [7:0]              kernel_size_in,
  input  logic                    flush,
  output logic                    flush_BUSY,
  output logic                    PE_EN,
  output logic                    m2p_valid,
  input  logic                    m2p_ready,
  output logic [DATA_WIDTH-1:0]   ifmap_data_M2P,
  output logic [DATA_WIDTH-1:0]   fltr_data_M2P,
  output logic [2*DATA_WIDTH-1:0] psum_data_M2P,
  output logic [7:0]              kernel_size,
  input  logic                    p2m_valid,
  output logic                    p2m_ready,
  input  logic [2*DATA_WIDTH-1:0] psum_data_P2M,
  output logic [2*DATA_WIDTH-1:0] psum_data_M2B,
  output logic                    m2b_valid,
  input  logic                    m2b_ready,
  output logic [15:0]             drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   ifmap;
    logic [DATA_WIDTH-1:0]   fltr;
    logic [2*DATA_WIDTH-1:0] psum;
  } beat_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  beat_t                   r_mem [FIFO_DEPTH];
  beat_t                   r_last_head;
  beat_t                   w_head;
  beat_t                   w_beat_in;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [7:0]              r_kernel_size;
  logic                    r_slice_vld;
  logic [2*DATA_WIDTH-1:0] r_slice_dat;
  logic                    w_fifo_empty;
  logic                    w_bus_xfer;
  logic                    w_match;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_slice_ld;

  assign w_fifo_empty = (r_count == '0);
  assign b_ready      = (r_state == RUN) && CASTER_EN && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_bus_xfer   = b_valid && b_ready;
  assign w_match      = (b_tag == ID) || b_tag[TAG_W-1];
  assign w_push       = w_bus_xfer && w_match;
  assign m2p_valid    = !w_fifo_empty;
  assign w_pop        = m2p_valid && m2p_ready;

  assign w_beat_in.ifmap = ifmap_data_B2M;
  assign w_beat_in.fltr  = fltr_data_B2M;
  assign w_beat_in.psum  = psum_data_B2M;

  // Once empty, outputs keep showing the last popped head rather than stale slots.
  assign w_head         = w_fifo_empty ? r_last_head : r_mem[r_rd_ptr];
  assign ifmap_data_M2P = w_head.ifmap;
  assign fltr_data_M2P  = w_head.fltr;
  assign psum_data_M2P  = w_head.psum;

  assign PE_EN       = (r_state != DISABLED);
  assign flush_BUSY  = (r_state == FLUSH);
  assign kernel_size = r_kernel_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_beat_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_head <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_last_head <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernel_size <= '0;
    end else if (w_bus_xfer) begin
      r_kernel_size <= kernel_size_in;
    end
  end

  // Psum return slice: full throughput when the bus keeps m2b_ready high.
  assign p2m_ready     = !r_slice_vld || m2b_ready;
  assign w_slice_ld    = p2m_valid && p2m_ready;
  assign m2b_valid     = r_slice_vld;
  assign psum_data_M2B = r_slice_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slice_vld <= 1'b0;
      r_slice_dat <= '0;
    end else if (w_slice_ld) begin
      r_slice_vld <= 1'b1;
      r_slice_dat <= psum_data_P2M;
    end else if (m2b_ready) begin
      r_slice_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DISABLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DISABLED: begin
        if (CASTER_EN) w_state_nxt = RUN;
      end
      RUN: begin
        if (flush) begin
          w_state_nxt = FLUSH;
        end else if (!CASTER_EN && w_fifo_empty) begin
          w_state_nxt = DISABLED;
        end
      end
      FLUSH: begin
        if (w_fifo_empty && !r_slice_vld) begin
          w_state_nxt = CASTER_EN ? RUN : DISABLED;
        end
      end
      default: w_state_nxt = DISABLED;
    endcase
  end

`ifdef MULTICASTER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_bus_xfer && !w_match && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_multicaster.sv
// Directed bench for multicaster: filtering, full/empty, streaming, flush, psum slice, async reset.
module tb_multicaster;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  id;
  logic        caster_en;
  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_tag;
  logic [15:0] ifmap_b2m;
  logic [15:0] fltr_b2m;
  logic [31:0] psum_b2m;
  logic [7:0]  ks_in;
  logic        flush;
  logic        flush_busy;
  logic        pe_en;
  logic        m2p_valid;
  logic        m2p_ready;
  logic [15:0] ifmap_m2p;
  logic [15:0] fltr_m2p;
  logic [31:0] psum_m2p;
  logic [7:0]  kernel_size;
  logic        p2m_valid;
  logic        p2m_ready;
  logic [31:0] psum_p2m;
  logic [31:0] psum_m2b;
  logic        m2b_valid;
  logic        m2b_ready;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] popq[$];
  logic [31:0] psq[$];

  always #5 clk = ~clk;

  multicaster dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID             (id),
    .CASTER_EN      (caster_en),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_tag          (b_tag),
    .ifmap_data_B2M (ifmap_b2m),
    .fltr_data_B2M  (fltr_b2m),
    .psum_data_B2M  (psum_b2m),
    .kernel_size_in (ks_in),
    .flush          (flush),
    .flush_BUSY     (flush_busy),
    .PE_EN          (pe_en),
    .m2p_valid      (m2p_valid),
    .m2p_ready      (m2p_ready),
    .ifmap_data_M2P (ifmap_m2p),
    .fltr_data_M2P  (fltr_m2p),
    .psum_data_M2P  (psum_m2p),
    .kernel_size    (kernel_size),
    .p2m_valid      (p2m_valid),
    .p2m_ready      (p2m_ready),
    .psum_data_P2M  (psum_p2m),
    .psum_data_M2B  (psum_m2b),
    .m2b_valid      (m2b_valid),
    .m2b_ready      (m2b_ready),
    .drop_cnt       (drop_cnt)
  );

  // Handshakes are sampled mid-cycle; the transfer lands on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && m2p_valid && m2p_ready) popq.push_back({ifmap_m2p, fltr_m2p, psum_m2p});
    if (rst_n && m2b_valid && m2b_ready) psq.push_back(psum_m2b);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input logic [2:0] tag, input logic [15:0] n);
    b_tag     = tag;
    ifmap_b2m = 16'h1000 + n;
    fltr_b2m  = 16'h2000 + n;
    psum_b2m  = 32'h3000_0000 + {16'h0, n};
    ks_in     = 8'h40 + n[7:0];
  endtask

  task automatic send_beat(input logic [2:0] tag, input logic [15:0] n);
    logic done;
    done = 1'b0;
    set_beat(tag, n);
    b_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (b_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    check("send_done", done, 1'b1);
  endtask

  initial begin
    int          acc;
    int          vcnt;
    int          idx;
    logic        rdy;
    logic        ld;
    logic [2:0]  pat;

    rst_n = 1'b0; id = 3'd2; caster_en = 1'b0; b_valid = 1'b0;
    b_tag = '0; ifmap_b2m = '0; fltr_b2m = '0; psum_b2m = '0; ks_in = '0;
    flush = 1'b0; m2p_ready = 1'b0; p2m_valid = 1'b0; psum_p2m = '0; m2b_ready = 1'b0;

    // Reset state
    #1;
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_m2p_valid", m2p_valid, 1'b0);
    check("rst_pe_en", pe_en, 1'b0);
    check("rst_flush_busy", flush_busy, 1'b0);
    check("rst_m2b_valid", m2b_valid, 1'b0);
    check("rst_ifmap", ifmap_m2p, 16'h0);
    check("rst_kernel", kernel_size, 8'h0);
    check("rst_drop", drop_cnt, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    caster_en = 1'b1;
    check("dis_pe_en", pe_en, 1'b0);
    @(posedge clk); #1;
    check("run_pe_en", pe_en, 1'b1);
    check("run_b_ready", b_ready, 1'b1);

    // Tag filtering: 2 and broadcast kept, 1 dropped
    m2p_ready = 1'b1;
    popq.delete();
    send_beat(3'd2, 16'h1);
    send_beat(3'd1, 16'h2);
    send_beat(3'b100, 16'h3);
    send_beat(3'd2, 16'h4);
    repeat (3) @(posedge clk);
    #1;
    check("filt_count", popq.size(), 3);
    check("filt_beat0", popq[0], 64'h1001_2001_3000_0001);
    check("filt_beat1", popq[1], 64'h1003_2003_3000_0003);
    check("filt_beat2", popq[2], 64'h1004_2004_3000_0004);
    check("filt_kernel", kernel_size, 8'h44);
`ifdef MULTICASTER_DROP_CNT_EN
    check("filt_drop", drop_cnt, 16'h1);
`else
    check("filt_drop", drop_cnt, 16'h0);
`endif

    // Fill to full with PE stalled, then release
    m2p_ready = 1'b0;
    popq.delete();
    acc = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(3'd2, 16'h10 + 16'(acc));
      rdy = b_ready;
      if (i == 1) begin
        check("lat_valid", m2p_valid, 1'b1);
        check("lat_ifmap", ifmap_m2p, 16'h1010);
      end
      if (i == 4) check("full_b_ready", b_ready, 1'b0);
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    b_valid = 1'b0;
    check("full_accepted", acc, 4);
    m2p_ready = 1'b1;
    check("pop_b_ready_same", b_ready, 1'b0);
    @(posedge clk); #1;
    check("pop_b_ready_next", b_ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("full_pop_count", popq.size(), 4);
    check("full_first", popq[0], 64'h1010_2010_3000_0010);
    check("full_last", popq[3], 64'h1013_2013_3000_0013);

    // Streaming push/pop, no bubbles
    popq.delete();
    vcnt = 0;
    acc = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(3'd2, 16'h20 + 16'(i));
      if (m2p_valid) vcnt++;
      if (b_ready) acc++;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    if (m2p_valid) vcnt++;
    check("stream_b_ready", acc, 6);
    check("stream_valid_cycles", vcnt, 6);
    @(posedge clk); #1;
    check("stream_empty", m2p_valid, 1'b0);
    check("stream_count", popq.size(), 6);
    check("stream_first", popq[0], 64'h1020_2020_3000_0020);
    check("stream_last", popq[5], 64'h1025_2025_3000_0025);
    check("stream_hold", ifmap_m2p, 16'h1025);

    // Flush with 3 beats buffered
    m2p_ready = 1'b0;
    popq.delete();
    for (int i = 0; i < 3; i++) send_beat(3'd2, 16'h30 + 16'(i));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_on", flush_busy, 1'b1);
    check("flush_b_ready", b_ready, 1'b0);
    m2p_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (!flush_busy) break;
      @(posedge clk); #1;
    end
    check("flush_busy_off", flush_busy, 1'b0);
    check("flush_back_run", b_ready, 1'b1);
    check("flush_pops", popq.size(), 3);
    check("flush_last", popq[2], 64'h1032_2032_3000_0032);

    // Psum slice with m2b_ready 1,0,1
    psq.delete();
    pat = 3'b101;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      p2m_valid = (idx < 3);
      psum_p2m  = 32'(idx + 1);
      m2b_ready = (c < 3) ? pat[c] : 1'b1;
      #1;
      if (c == 1) begin
        check("slice_valid", m2b_valid, 1'b1);
        check("slice_data", psum_m2b, 32'h1);
        check("slice_stall", p2m_ready, 1'b0);
      end
      ld = p2m_valid && p2m_ready;
      @(posedge clk); #1;
      if (ld) idx++;
    end
    p2m_valid = 1'b0;
    check("slice_count", psq.size(), 3);
    check("slice_0", psq[0], 32'h1);
    check("slice_1", psq[1], 32'h2);
    check("slice_2", psq[2], 32'h3);
    check("slice_empty", m2b_valid, 1'b0);

    // Asynchronous reset with 2 beats buffered
    m2p_ready = 1'b0;
    send_beat(3'd2, 16'h40);
    send_beat(3'd2, 16'h41);
    check("pre_rst_valid", m2p_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_m2p_valid", m2p_valid, 1'b0);
    check("arst_b_ready", b_ready, 1'b0);
    check("arst_pe_en", pe_en, 1'b0);
    check("arst_ifmap", ifmap_m2p, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    popq.delete();
    m2p_ready = 1'b1;
    send_beat(3'd2, 16'h50);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_count", popq.size(), 1);
    check("post_rst_beat", popq[0], 64'h1050_2050_3000_0050);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
